// File: rtl/main_memory_pkg.sv
// Shared definitions for the main-memory initiator.
//  - DATAWIDTH_BUS : default width of the address / write-data / read-data buses
//  - mm_state_e    : initiator FSM states (IDLE, WAIT_ACK, RELEASE)
//  - mm_op_e       : request operation encoding (0 = read, 1 = write)
//  - op_strobes()  : maps an operation onto the {RD, WRMain} strobe pair
package main_memory_pkg;

  localparam int DATAWIDTH_BUS = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RELEASE  = 2'd2
  } mm_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mm_op_e;

  // Returns {rd, wr_main}; exactly one strobe is set so both can never be high together.
  function automatic logic [1:0] op_strobes(input mm_op_e op);
    logic [1:0] strobes;
    case (op)
      OP_READ:  strobes = 2'b10;
      OP_WRITE: strobes = 2'b01;
      default:  strobes = 2'b00;
    endcase
    return strobes;
  endfunction

endpackage

// File: rtl/main_memory_initiator_if.sv
// Request + memory-bus bundle of the main-memory initiator.
//  Request side : req, wr, addr, wdata in; busy, done, err, rdata out
//  Memory side  : a, b, rd, wr_main out; ack, data_in in
//  master modport = the initiator, slave modport = requester plus memory.
interface main_memory_initiator_if #(
  parameter int DW = main_memory_pkg::DATAWIDTH_BUS
) ();

  logic          req;
  logic          wr;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          rd;
  logic          wr_main;
  logic          ack;
  logic [DW-1:0] data_in;

  modport master (
    input  req, wr, addr, wdata, ack, data_in,
    output busy, done, err, rdata, a, b, rd, wr_main
  );

  modport slave (
    output req, wr, addr, wdata, ack, data_in,
    input  busy, done, err, rdata, a, b, rd, wr_main
  );

endinterface

// File: rtl/mm_timeout_counter.sv
// Cycle counter bounding how long the initiator waits for ACK.
//  clk, rst_n : clock and asynchronous active-low reset
//  clr        : synchronous clear (wins over en)
//  en         : count one cycle
//  tc         : count has reached TIMEOUT_CYCLES-1; never set when TIMEOUT_CYCLES == 0
module mm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TOCNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TOCNT_WIDTH-1:0] TC_VALUE =
    (TIMEOUT_CYCLES == 0) ? '0 : TOCNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TOCNT_WIDTH-1:0] cnt_r;

  // Counter register: cleared outside WAIT_ACK, advances while ACK is awaited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + TOCNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (TIMEOUT_CYCLES != 0) && (cnt_r == TC_VALUE);

endmodule

// File: rtl/main_memory_initiator.sv
// Bus master for the main-memory RD/WRMain/ACK 4-phase handshake.
//  MAIN_MEMORY_INITIATOR_CLOCK_50      : system clock, rising edge
//  MAIN_MEMORY_INITIATOR_ResetInLow_In : asynchronous reset, active low
//  bus (master modport):
//    req/wr/addr/wdata in       - one request at a time, sampled only when idle
//    busy                       - (state != IDLE) | ack, combinational
//    done/err                   - one-cycle completion pulse / timeout flag
//    rdata                      - last successfully read word, held
//    a/b/rd/wr_main out, ack/data_in in - memory side
module main_memory_initiator
  import main_memory_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = main_memory_pkg::DATAWIDTH_BUS,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TOCNT_WIDTH    = 8
) (
  input logic                      MAIN_MEMORY_INITIATOR_CLOCK_50,
  input logic                      MAIN_MEMORY_INITIATOR_ResetInLow_In,
  main_memory_initiator_if.master  bus
);

  mm_state_e                state_r;
  logic [DATAWIDTH_BUS-1:0] a_r;
  logic [DATAWIDTH_BUS-1:0] b_r;
  logic [DATAWIDTH_BUS-1:0] rdata_r;
  logic                     rd_r;
  logic                     wr_main_r;
  logic                     done_r;
  logic                     err_r;
  logic                     to_clr_s;
  logic                     to_en_s;
  logic                     to_tc_s;

  // The counter sits at zero outside WAIT_ACK so each wait starts from a clean count.
  assign to_clr_s = (state_r != ST_WAIT_ACK);
  assign to_en_s  = (state_r == ST_WAIT_ACK) && !bus.ack;

  mm_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TOCNT_WIDTH    (TOCNT_WIDTH)
  ) u_timeout (
    .clk   (MAIN_MEMORY_INITIATOR_CLOCK_50),
    .rst_n (MAIN_MEMORY_INITIATOR_ResetInLow_In),
    .clr   (to_clr_s),
    .en    (to_en_s),
    .tc    (to_tc_s)
  );

  // Handshake FSM with all bus and status registers.
  always_ff @(posedge MAIN_MEMORY_INITIATOR_CLOCK_50 or negedge MAIN_MEMORY_INITIATOR_ResetInLow_In) begin
    if (!MAIN_MEMORY_INITIATOR_ResetInLow_In) begin
      state_r   <= ST_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      rdata_r   <= '0;
      rd_r      <= 1'b0;
      wr_main_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A request while ACK is still high (late ACK after a timeout) is dropped.
          if (bus.req && !bus.ack) begin
            a_r                  <= bus.addr;
            b_r                  <= bus.wdata;
            {rd_r, wr_main_r}    <= op_strobes(mm_op_e'(bus.wr));
            state_r              <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // ACK is checked first so it wins over a timeout in the same cycle.
          if (bus.ack) begin
            if (rd_r) begin
              rdata_r <= bus.data_in;
            end
            rd_r      <= 1'b0;
            wr_main_r <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_RELEASE;
          end else if (to_tc_s) begin
            rd_r      <= 1'b0;
            wr_main_r <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (!bus.ack) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          rd_r      <= 1'b0;
          wr_main_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state_r != ST_IDLE) | bus.ack;
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.rdata   = rdata_r;
  assign bus.a       = a_r;
  assign bus.b       = b_r;
  assign bus.rd      = rd_r;
  assign bus.wr_main = wr_main_r;

endmodule
